// File: rtl/biu_arb.sv
// biu_arb: shares one memory port between IFU and LSU, one transaction at a time, LSU priority with IFU starvation guard
module biu_arb #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  ifu_req_valid_i,
   output logic                  ifu_req_ready_o,
   input  logic [ADDR_WIDTH-1:0] ifu_req_addr_i,
   output logic                  ifu_rsp_valid_o,
   output logic [XLEN-1:0]       ifu_rsp_rdata_o,
   output logic                  ifu_rsp_err_o,
   input  logic                  lsu_req_valid_i,
   output logic                  lsu_req_ready_o,
   input  logic [ADDR_WIDTH-1:0] lsu_req_addr_i,
   input  logic                  lsu_req_wen_i,
   input  logic [XLEN-1:0]       lsu_req_wdata_i,
   input  logic [XLEN/8-1:0]     lsu_req_wmask_i,
   output logic                  lsu_rsp_valid_o,
   output logic [XLEN-1:0]       lsu_rsp_rdata_o,
   output logic                  lsu_rsp_err_o,
   output logic                  bus_req_valid_o,
   input  logic                  bus_req_ready_i,
   output logic [ADDR_WIDTH-1:0] bus_req_addr_o,
   output logic                  bus_req_wen_o,
   output logic [XLEN-1:0]       bus_req_wdata_o,
   output logic [XLEN/8-1:0]     bus_req_wmask_o,
   input  logic                  bus_rsp_valid_i,
   input  logic [XLEN-1:0]       bus_rsp_rdata_i,
   input  logic                  bus_rsp_err_i
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t state;
   logic [CW-1:0] starve_cnt;
   logic owner_lsu, drop, ifu_ok, force_ifu, grant_lsu, grant_ifu;
   always_comb begin
      ifu_ok    = ifu_req_valid_i && !flush_i;
      force_ifu = ifu_ok && starve_cnt == CW'(STARVE_MAX);
      grant_lsu = state == IDLE && lsu_req_valid_i && !force_ifu;
      grant_ifu = state == IDLE && ifu_ok && (!lsu_req_valid_i || force_ifu);
   end
   assign ifu_req_ready_o = grant_ifu;
   assign lsu_req_ready_o = grant_lsu;
   assign bus_req_valid_o = state == REQ;
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         starve_cnt      <= '0;
         owner_lsu       <= 1'b0;
         drop            <= 1'b0;
         ifu_rsp_valid_o <= 1'b0;
         ifu_rsp_rdata_o <= '0;
         ifu_rsp_err_o   <= 1'b0;
         lsu_rsp_valid_o <= 1'b0;
         lsu_rsp_rdata_o <= '0;
         lsu_rsp_err_o   <= 1'b0;
         bus_req_addr_o  <= '0;
         bus_req_wen_o   <= 1'b0;
         bus_req_wdata_o <= '0;
         bus_req_wmask_o <= '0;
      end else begin
         ifu_rsp_valid_o <= 1'b0;
         lsu_rsp_valid_o <= 1'b0;
         case (state)
            IDLE: if (grant_lsu || grant_ifu) begin
               state           <= REQ;
               owner_lsu       <= grant_lsu;
               drop            <= 1'b0;
               bus_req_addr_o  <= grant_lsu ? lsu_req_addr_i : ifu_req_addr_i;
               bus_req_wen_o   <= grant_lsu && lsu_req_wen_i;
               bus_req_wdata_o <= grant_lsu ? lsu_req_wdata_i : '0;
               bus_req_wmask_o <= grant_lsu ? lsu_req_wmask_i : '0;
               starve_cnt      <= grant_ifu ? '0 :
                                  (ifu_ok && starve_cnt != CW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
            end
            REQ: begin
               drop <= drop || (flush_i && !owner_lsu);
               if (bus_req_ready_i) state <= WAIT;
            end
            WAIT: if (bus_rsp_valid_i) begin
               state <= IDLE;
               drop  <= 1'b0;
               // a flush arriving with the response still discards the fetch
               if (owner_lsu) begin
                  lsu_rsp_valid_o <= 1'b1;
                  lsu_rsp_rdata_o <= bus_rsp_rdata_i;
                  lsu_rsp_err_o   <= bus_rsp_err_i;
               end else if (!(drop || flush_i)) begin
                  ifu_rsp_valid_o <= 1'b1;
                  ifu_rsp_rdata_o <= bus_rsp_rdata_i;
                  ifu_rsp_err_o   <= bus_rsp_err_i;
               end
            end else drop <= drop || (flush_i && !owner_lsu);
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_biu_arb.sv
// tb_biu_arb: directed scenarios plus random traffic checked against a transaction-level model
module tb_biu_arb;
   localparam int SM = 4;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_req_addr = '0, ifu_rsp_rdata;
   logic lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0, lsu_rsp_valid, lsu_rsp_err;
   logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0, lsu_rsp_rdata;
   logic [3:0] lsu_req_wmask = '0, bus_req_wmask;
   logic bus_req_valid, bus_req_ready = 1'b0, bus_req_wen, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
   logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata = '0;
   int checks = 0, errors = 0;
   // model: arbiter free / request outstanding / awaiting response, plus the accepted transaction
   bit m_idle, m_req, m_wait, m_lsu, m_drop, m_wen;
   int m_starve;
   logic [31:0] m_addr, m_wdata;
   logic [3:0] m_wmask;
   bit e_ifu_pulse, e_lsu_pulse, e_ifu_err, e_lsu_err;
   logic [31:0] e_ifu_data, e_lsu_data;
   int wins_n;
   logic [7:0] wins;

   biu_arb #(.XLEN(32), .ADDR_WIDTH(32), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready), .ifu_req_addr_i(ifu_req_addr),
      .ifu_rsp_valid_o(ifu_rsp_valid), .ifu_rsp_rdata_o(ifu_rsp_rdata), .ifu_rsp_err_o(ifu_rsp_err),
      .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready), .lsu_req_addr_i(lsu_req_addr),
      .lsu_req_wen_i(lsu_req_wen), .lsu_req_wdata_i(lsu_req_wdata), .lsu_req_wmask_i(lsu_req_wmask),
      .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rsp_rdata_o(lsu_rsp_rdata), .lsu_rsp_err_o(lsu_rsp_err),
      .bus_req_valid_o(bus_req_valid), .bus_req_ready_i(bus_req_ready), .bus_req_addr_o(bus_req_addr),
      .bus_req_wen_o(bus_req_wen), .bus_req_wdata_o(bus_req_wdata), .bus_req_wmask_o(bus_req_wmask),
      .bus_rsp_valid_i(bus_rsp_valid), .bus_rsp_rdata_i(bus_rsp_rdata), .bus_rsp_err_i(bus_rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_idle = 1; m_req = 0; m_wait = 0; m_lsu = 0; m_drop = 0; m_wen = 0;
      m_starve = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
      e_ifu_pulse = 0; e_lsu_pulse = 0; e_ifu_err = 0; e_lsu_err = 0;
      e_ifu_data = '0; e_lsu_data = '0;
   endfunction

   task automatic quiet();
      flush = 0; ifu_req_valid = 0; lsu_req_valid = 0; lsu_req_wen = 0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_err = 0;
   endtask

   // inputs are already driven (just after negedge); check, advance the model, move to next negedge
   task automatic step();
      bit ok, frc, gi, gl;
      #1;
      ok  = ifu_req_valid && !flush;
      frc = ok && m_starve == SM;
      gl  = m_idle && lsu_req_valid && !frc;
      gi  = m_idle && ok && (!lsu_req_valid || frc);
      check("ifu_ready", 64'(ifu_req_ready), 64'(gi));
      check("lsu_ready", 64'(lsu_req_ready), 64'(gl));
      check("bus_valid", 64'(bus_req_valid), 64'(m_req));
      if (m_req) begin
         check("bus_addr", 64'(bus_req_addr), 64'(m_addr));
         check("bus_wen", 64'(bus_req_wen), 64'(m_wen));
         check("bus_wmask", 64'(bus_req_wmask), 64'(m_wmask));
         if (m_lsu) check("bus_wdata", 64'(bus_req_wdata), 64'(m_wdata));
      end
      check("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(e_ifu_pulse));
      check("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(e_lsu_pulse));
      check("ifu_rsp", {31'd0, ifu_rsp_err, ifu_rsp_rdata}, {31'd0, e_ifu_err, e_ifu_data});
      check("lsu_rsp", {31'd0, lsu_rsp_err, lsu_rsp_rdata}, {31'd0, e_lsu_err, e_lsu_data});
      if (gl || gi) begin
         wins = {wins[6:0], gl};
         wins_n++;
      end
      e_ifu_pulse = 0; e_lsu_pulse = 0;
      if (rst) model_reset();
      else if (gl || gi) begin
         m_idle = 0; m_req = 1; m_lsu = gl; m_drop = 0;
         m_addr = gl ? lsu_req_addr : ifu_req_addr;
         m_wen = gl && lsu_req_wen;
         m_wdata = lsu_req_wdata;
         m_wmask = gl ? lsu_req_wmask : 4'h0;
         m_starve = gi ? 0 : ok ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : m_starve;
      end else if (m_req || m_wait) begin
         if (flush && !m_lsu) m_drop = 1;
         if (m_req && bus_req_ready) begin
            m_req = 0; m_wait = 1;
         end else if (m_wait && bus_rsp_valid) begin
            m_wait = 0; m_idle = 1;
            if (m_lsu) begin
               e_lsu_pulse = 1; e_lsu_data = bus_rsp_rdata; e_lsu_err = bus_rsp_err;
            end else if (!m_drop) begin
               e_ifu_pulse = 1; e_ifu_data = bus_rsp_rdata; e_ifu_err = bus_rsp_err;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      model_reset();
      rst = 0;
      step();
      // single fetch, minimum turnaround
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; step();
      quiet(); bus_req_ready = 1; step();
      quiet(); bus_rsp_valid = 1; bus_rsp_rdata = 32'h0000_0013; step();
      quiet(); step();
      check("fetch_data", 64'(ifu_rsp_rdata), 64'h13);
      // simultaneous requests: LSU store first, IFU after LSU drops
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
      lsu_req_valid = 1; lsu_req_addr = 32'h1000; lsu_req_wen = 1;
      lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; step();
      check("store_addr", 64'(bus_req_addr), 64'h1000);
      check("store_wdata", 64'(bus_req_wdata), 64'hDEAD_BEEF);
      lsu_req_valid = 0; bus_req_ready = 1; step();
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'h1; step();
      bus_rsp_valid = 0; step();
      check("ifu_after_lsu", 64'(bus_req_addr), 64'h8000_0004);
      quiet(); bus_req_ready = 1; step();
      quiet(); bus_rsp_valid = 1; bus_rsp_rdata = 32'h2; step();
      // starvation guard: LSU and IFU both held valid
      quiet(); wins = '0; wins_n = 0;
      ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_wen = 0;
      bus_req_ready = 1; bus_rsp_valid = 1;
      for (int i = 0; i < 18; i++) begin
         bus_rsp_rdata = 32'(i);
         step();
      end
      check("starve_count", 64'(wins_n), 64'd6);
      check("starve_order", 64'(wins[5:0]), 64'b111101);
      // bus not ready for three cycles, requesters keep asking
      quiet(); lsu_req_valid = 1; lsu_req_addr = 32'h2000; lsu_req_wmask = 4'h3; step();
      ifu_req_valid = 1;
      for (int i = 0; i < 3; i++) begin
         lsu_req_addr = 32'h3000 + 32'(i);
         step();
      end
      check("stall_addr", 64'(bus_req_addr), 64'h2000);
      quiet(); bus_req_ready = 1; step();
      quiet(); bus_rsp_valid = 1; bus_rsp_rdata = 32'h55; step();
      // flush during a fetch in WAIT
      quiet(); ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100; step();
      quiet(); bus_req_ready = 1; step();
      quiet(); flush = 1; step();
      quiet(); bus_rsp_valid = 1; bus_rsp_rdata = 32'hBAD; step();
      quiet(); lsu_req_valid = 1; lsu_req_addr = 32'h4000; step();
      quiet(); bus_req_ready = 1; step();
      quiet(); bus_rsp_valid = 1; bus_rsp_rdata = 32'h77; step();
      quiet(); step();
      // reset while waiting, then a stray response
      lsu_req_valid = 1; lsu_req_addr = 32'h5000; step();
      quiet(); bus_req_ready = 1; step();
      quiet(); rst = 1; step();
      rst = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'hFFFF; step();
      quiet(); step();
      check("rst_lsu_data", 64'(lsu_rsp_rdata), 64'h0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 7) == 0);
         ifu_req_valid = 1'($urandom);
         ifu_req_addr = $urandom;
         lsu_req_valid = 1'($urandom);
         lsu_req_addr = $urandom;
         lsu_req_wen = 1'($urandom);
         lsu_req_wdata = $urandom;
         lsu_req_wmask = 4'($urandom);
         bus_req_ready = 1'($urandom);
         bus_rsp_valid = ($urandom_range(0, 2) == 0);
         bus_rsp_rdata = $urandom;
         bus_rsp_err = 1'($urandom);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
